// File: rtl/mem_refill_arbiter.sv
// Arbitrates the single-ported backing memory between I-cache refills and D-cache refills/write-backs.
// Each grant runs one LINE_WORDS burst, one beat per cycle, with read returns MEM_LAT cycles after issue.
// There is no backpressure: requests wait in IDLE, and a granted burst always runs to completion.
module mem_refill_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 32,
  parameter int LINE_WORDS = 4,
  parameter int MEM_LAT    = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          i_req,
  input  logic [ADDR_WIDTH-1:0]         i_addr,
  output logic                          i_gnt,
  output logic                          i_rvalid,
  output logic                          i_done,
  input  logic                          d_req,
  input  logic                          d_we,
  input  logic [ADDR_WIDTH-1:0]         d_addr,
  input  logic [DATA_WIDTH-1:0]         d_wdata,
  output logic                          d_wready,
  output logic                          d_gnt,
  output logic                          d_rvalid,
  output logic                          d_done,
  output logic [DATA_WIDTH-1:0]         rdata,
  output logic [$clog2(LINE_WORDS)-1:0] beat_idx,
  output logic                          mem_en,
  output logic                          mem_we,
  output logic [ADDR_WIDTH-1:0]         mem_addr,
  output logic [DATA_WIDTH-1:0]         mem_wdata,
  input  logic [DATA_WIDTH-1:0]         mem_rdata,
  output logic                          busy
);

  localparam int BW  = $clog2(LINE_WORDS);
  localparam int CW  = BW + 1;
  localparam int OFF = BW + 2;
  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'((1 << OFF) - 1);
  localparam logic [CW-1:0] LAST_BEAT = CW'(LINE_WORDS - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN, DONE} state_t;

  state_t                 state_q, state_d;
  logic                   owner_q, owner_d;   // 1 = D-side
  logic                   wr_q, wr_d;
  logic                   last_q, last_d;     // 1 = D-side owned the previous burst
  logic [ADDR_WIDTH-1:0]  base_q, base_d;
  logic [CW-1:0]          issue_cnt_q, issue_cnt_d;
  logic [CW-1:0]          ret_cnt_q, ret_cnt_d;
  logic [MEM_LAT-1:0]     vld_sr_q, vld_sr_d;

  logic issuing;
  logic rd_vld;
  logic grant_d_side;

  assign issuing = (state_q == ISSUE);
  assign rd_vld  = vld_sr_q[MEM_LAT-1];

  // On a tie the side that did not own the last burst wins, so continuous requesters alternate.
  assign grant_d_side = d_req && (!i_req || !last_q);

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    last_d      = last_q;
    base_d      = base_q;
    issue_cnt_d = issue_cnt_q;
    ret_cnt_d   = ret_cnt_q;

    vld_sr_d    = vld_sr_q << 1;
    vld_sr_d[0] = issuing && !wr_q;

    if (rd_vld) begin
      ret_cnt_d = ret_cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (grant_d_side) begin
          owner_d     = 1'b1;
          wr_d        = d_we;
          base_d      = d_addr & ~LOW_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = ISSUE;
        end else if (i_req) begin
          owner_d     = 1'b0;
          wr_d        = 1'b0;
          base_d      = i_addr & ~LOW_MASK;
          issue_cnt_d = '0;
          ret_cnt_d   = '0;
          state_d     = ISSUE;
        end
      end
      ISSUE: begin
        issue_cnt_d = issue_cnt_q + 1'b1;
        if (issue_cnt_q == LAST_BEAT) begin
          state_d = wr_q ? DONE : DRAIN;
        end
      end
      DRAIN: begin
        // Leave on the last return itself so done follows the final beat by one cycle.
        if (rd_vld && ret_cnt_q == LAST_BEAT) begin
          state_d = DONE;
        end
      end
      DONE: begin
        last_d  = owner_q;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      owner_q     <= 1'b0;
      wr_q        <= 1'b0;
      last_q      <= 1'b0;
      base_q      <= '0;
      issue_cnt_q <= '0;
      ret_cnt_q   <= '0;
      vld_sr_q    <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      last_q      <= last_d;
      base_q      <= base_d;
      issue_cnt_q <= issue_cnt_d;
      ret_cnt_q   <= ret_cnt_d;
      vld_sr_q    <= vld_sr_d;
    end
  end

  assign busy      = (state_q != IDLE);
  assign i_gnt     = busy && !owner_q;
  assign d_gnt     = busy && owner_q;

  assign mem_en    = issuing;
  assign mem_we    = issuing && wr_q;
  assign mem_addr  = issuing ? (base_q + (ADDR_WIDTH'(issue_cnt_q) << 2)) : '0;
  assign mem_wdata = (issuing && wr_q) ? d_wdata : '0;
  assign d_wready  = issuing && wr_q;

  assign i_rvalid  = rd_vld && !owner_q;
  assign d_rvalid  = rd_vld && owner_q;
  assign rdata     = mem_rdata;

  // Write bursts report the beat being consumed; read bursts report the beat being returned.
  assign beat_idx  = wr_q ? issue_cnt_q[BW-1:0] : ret_cnt_q[BW-1:0];

  assign i_done    = (state_q == DONE) && !owner_q;
  assign d_done    = (state_q == DONE) && owner_q;

endmodule

// File: doc/mem_refill_arbiter.md
Name: mem_refill_arbiter

Overview:
- Shares the single-ported backing memory between the instruction-cache refill path (I-side, read-only) and the data-cache refill/write-back path (D-side, read or write).
- Grants one requester at a time and runs a fixed-length, line-sized burst of word accesses.
- Returns read beats with a beat index and pulses completion so the requesting cache can release its pipeline stall.
- Sits between the two caches and data/instruction backing memory, below the pipeline.

Parameters:
- DATA_WIDTH, 32, word width of the memory and data buses.
- ADDR_WIDTH, 32, byte-address width.
- LINE_WORDS, 4, beats per burst (power of two, ≥2).
- MEM_LAT, 1, fixed read latency of the memory in cycles (≥1).

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- i_req  in  1  I-side refill request; held until i_done.
- i_addr  in  ADDR_WIDTH  I-side line address; low log2(LINE_WORDS)+2 bits ignored.
- i_gnt  out  1  I-side owns the memory.
- i_rvalid  out  1  rdata holds an I-side beat.
- i_done  out  1  one-cycle I-side burst completion pulse.
- d_req  in  1  D-side request; held until d_done.
- d_we  in  1  D-side burst is a write (write-back).
- d_addr  in  ADDR_WIDTH  D-side line address; low bits ignored as for i_addr.
- d_wdata  in  DATA_WIDTH  D-side write beat, sampled when d_wready=1.
- d_wready  out  1  D-side write beat consumed this cycle.
- d_gnt  out  1  D-side owns the memory.
- d_rvalid  out  1  rdata holds a D-side beat.
- d_done  out  1  one-cycle D-side burst completion pulse.
- rdata  out  DATA_WIDTH  returning read beat, shared by both sides.
- beat_idx  out  $clog2(LINE_WORDS)  index of the beat on rdata, or of the beat on d_wready for writes.
- mem_en  out  1  memory access this cycle.
- mem_we  out  1  memory write this cycle.
- mem_addr  out  ADDR_WIDTH  word-aligned byte address.
- mem_wdata  out  DATA_WIDTH  memory write data.
- mem_rdata  in  DATA_WIDTH  memory read data, valid MEM_LAT cycles after a read issue.
- busy  out  1  state != IDLE.

Behaviour:
- FSM states: IDLE, ISSUE, DRAIN, DONE. Registers: state, owner (I/D), write flag, aligned base, issue counter, return counter, last_owner, MEM_LAT-deep read-valid shift register.
- Reset: state=IDLE, last_owner=I (so D wins the first tie). All outputs 0: gnt, rvalid, done, wready, mem_en, mem_we, busy. rdata=mem_rdata passthrough, no reset requirement. mem_addr=0, mem_wdata=0 (don't care while mem_en=0), beat_idx=0.
- IDLE:
  - Only one requester active → that side is granted.
  - Both active → the side ≠ last_owner is granted.
  - On grant, latch base = addr with low bits cleared, latch d_we for D, move to ISSUE. The gnt output rises the next cycle and stays high through DONE.
- ISSUE: one beat per cycle for exactly LINE_WORDS cycles.
  - Each cycle: mem_en=1, mem_addr=base+4*issue_cnt.
  - Write burst: mem_we=1, mem_wdata=d_wdata, d_wready=1, beat_idx=issue_cnt.
  - After the last beat: write → DONE, read → DRAIN.
- Read returns:
  - Each issue pushes a 1 into the shift register; its output marks mem_rdata valid MEM_LAT cycles later.
  - Valid output drives i_rvalid or d_rvalid by owner; beat_idx=return counter, incremented per return.
  - Returns may overlap ISSUE.
- DRAIN: wait until the return counter reaches LINE_WORDS, then go to DONE.
- DONE: one cycle with i_done or d_done=1. Update last_owner=owner, drop gnt, go to IDLE. A new grant is evaluated in the following IDLE cycle.
- Read latency: first beat arrives 1+MEM_LAT cycles after the grant cycle. Total read burst from grant to done = LINE_WORDS+MEM_LAT+1 cycles; write burst = LINE_WORDS+1 cycles.
- A requester dropping req mid-burst is ignored; the burst completes. Address or we changes after grant are ignored.
- No starvation: with both sides continuously requesting, grants strictly alternate.
- rst_n asserted mid-burst: immediate return to IDLE with reset outputs. In-flight returns are discarded and the shift register is cleared.
- beat_idx wraps naturally at LINE_WORDS; counters are $clog2(LINE_WORDS)+1 bits wide.

Test Plan:
- LINE_WORDS=4, MEM_LAT=1, i_req with i_addr=0x104 → mem_addr 0x100, 0x104, 0x108, 0x10C on 4 consecutive cycles with mem_we=0. i_rvalid beats 0–3 one cycle after each issue; i_done pulses once, 6 cycles after the grant cycle.
- d_req with d_we=1, d_addr=0x2000, wdata 0xA0..0xA3 → mem_we=1 writes of 0xA0..0xA3 to 0x2000..0x200C. d_wready high for 4 cycles; d_done on the 5th cycle; no rvalid.
- i_req and d_req rise together right after reset → D granted first, then I granted on the cycle after d_done. Both held continuously → grants alternate D, I, D, I.
- rst_n pulsed low during the second read beat → all outputs 0 asynchronously. After release: no rvalid, done or mem_en until a fresh request, then a normal burst.
- MEM_LAT=3, LINE_WORDS=8 read → 8 rvalid beats, beat_idx 0..7 in order, first beat 4 cycles after the grant cycle; done exactly 1 cycle after the last beat.
- d_req dropped after grant during a read → burst still completes with all beats and d_done; no I grant before DONE.
